// File: rtl/strobe_byte_receiver.sv
// Receiving end of the 8-bit strobed parallel byte link: synchronise, capture one byte per strobe, frame into a buffer.
// Optional glitch filter on the strobe: define RX_GLITCH_FILTER_EN.
module strobe_byte_receiver #(
  parameter int unsigned BUFFER_LEN    = 1025,
  parameter int unsigned ADDR_W        = 11,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned GAP_CYCLES    = 1000000,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_strobe,
  input  logic              rearm,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow,
  output logic              gap_timeout,
  output logic [ADDR_W-1:0] byte_count
);

  localparam int unsigned IDX_W = (BUFFER_LEN > 1) ? $clog2(BUFFER_LEN) : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] LEN_A    = ADDR_W'(BUFFER_LEN);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  if (SYNC_STAGES < 2 || FILTER_CYCLES < 1 || (BUFFER_LEN >> ADDR_W) != 0) begin : g_param_check
    $error("strobe_byte_receiver: invalid parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE} state_t;

  state_t                       state, state_d;
  logic [SYNC_STAGES-1:0]       strobe_sync;
  logic [SYNC_STAGES-1:0][7:0]  data_sync;
  logic                         strobe_s;
  logic [7:0]                   data_s;
  logic                         sample;
  logic [GAP_W-1:0]             gap_cnt, gap_d;
  logic [ADDR_W-1:0]            count_d, count_inc;
  logic                         ovf_d, gto_d, wr_en;
  logic [7:0]                   buf_mem [BUFFER_LEN];

  // Strobe and data cross into clk together so the captured byte matches its strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      strobe_sync <= '0;
      data_sync   <= '0;
    end else begin
      strobe_sync <= {strobe_sync[SYNC_STAGES-2:0], rx_strobe};
      data_sync   <= {data_sync[SYNC_STAGES-2:0], rx_data};
    end
  end

  assign strobe_s = strobe_sync[SYNC_STAGES-1];
  assign data_s   = data_sync[SYNC_STAGES-1];

`ifdef RX_GLITCH_FILTER_EN
  localparam int unsigned FLT_W = $clog2(FILTER_CYCLES + 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_CYCLES - 1);

  logic [FLT_W-1:0] lo_cnt, hi_cnt;
  logic             armed;

  // armed: the preceding low run lasted at least FILTER_CYCLES cycles
  assign sample = strobe_s & armed & (hi_cnt == FLT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lo_cnt <= '0;
      hi_cnt <= '0;
      armed  <= 1'b0;
    end else if (strobe_s) begin
      lo_cnt <= '0;
      if (hi_cnt != FLT_LAST) hi_cnt <= hi_cnt + FLT_W'(1);
      if (sample) armed <= 1'b0;
    end else begin
      hi_cnt <= '0;
      if (lo_cnt != FLT_LAST) lo_cnt <= lo_cnt + FLT_W'(1);
      armed <= (lo_cnt == FLT_LAST);
    end
  end
`else
  logic strobe_prev;

  assign sample = strobe_s & ~strobe_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) strobe_prev <= 1'b0;
    else      strobe_prev <= strobe_s;
  end
`endif

  // Frame control; byte_count doubles as the write pointer
  always_comb begin
    state_d   = state;
    count_d   = byte_count;
    gap_d     = gap_cnt;
    ovf_d     = overflow;
    gto_d     = gap_timeout;
    wr_en     = 1'b0;
    count_inc = byte_count + ADDR_W'(1);
    if (rearm) begin
      state_d = S_IDLE;
      count_d = '0;
      gap_d   = '0;
      ovf_d   = 1'b0;
      gto_d   = 1'b0;
    end else begin
      case (state)
        S_IDLE, S_RECV: begin
          if (sample) begin
            wr_en   = 1'b1;
            count_d = count_inc;
            gap_d   = '0;
            if (data_s == 8'h00) begin
              state_d = S_DONE;
            end else if (count_inc == LEN_A) begin
              state_d = S_DONE;
              ovf_d   = 1'b1;
            end else begin
              state_d = S_RECV;
            end
          end else if (state == S_RECV) begin
            gap_d = gap_cnt + GAP_W'(1);
            if (gap_d == GAP_LAST) begin
              state_d = S_DONE;
              gto_d   = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      byte_count  <= '0;
      gap_cnt     <= '0;
      overflow    <= 1'b0;
      gap_timeout <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_d;
      byte_count  <= count_d;
      gap_cnt     <= gap_d;
      overflow    <= ovf_d;
      gap_timeout <= gto_d;
      busy        <= (state_d == S_RECV);
      frame_done  <= (state_d == S_DONE);
    end
  end

  // Buffer contents survive reset so a partial frame can still be inspected
  always_ff @(posedge clk) begin
    if (wr_en) buf_mem[IDX_W'(byte_count)] <= data_s;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                rd_data <= '0;
    else if (rd_addr < LEN_A) rd_data <= buf_mem[IDX_W'(rd_addr)];
    else                     rd_data <= '0;
  end

endmodule

// File: tb/tb_strobe_byte_receiver.sv
// Directed bench for strobe_byte_receiver: vector table for whole frames plus hand sequences for timing corners.
module tb_strobe_byte_receiver;

  localparam int unsigned BUFFER_LEN    = 8;
  localparam int unsigned ADDR_W        = 4;
  localparam int unsigned SYNC_STAGES   = 2;
  localparam int unsigned GAP_CYCLES    = 64;
  localparam int unsigned FILTER_CYCLES = 4;
`ifdef RX_GLITCH_FILTER_EN
  localparam int unsigned LAT = SYNC_STAGES + FILTER_CYCLES;
`else
  localparam int unsigned LAT = SYNC_STAGES + 1;
`endif

  localparam logic [1:0] OP_STROBE = 2'd0;
  localparam logic [1:0] OP_REARM  = 2'd1;
  localparam logic [1:0] OP_READ   = 2'd2;

  logic              clk, rst, rx_strobe, rearm;
  logic [7:0]        rx_data, rd_data;
  logic [ADDR_W-1:0] rd_addr, byte_count;
  logic              busy, frame_done, overflow, gap_timeout;

  int n_vec = 0;
  int n_mis = 0;

  typedef struct {
    logic [1:0]        op;
    logic [7:0]        data;
    logic [ADDR_W-1:0] addr;
    logic              e_busy, e_done, e_ovf, e_gto;
    logic [ADDR_W-1:0] e_count;
    logic [7:0]        e_rd;
  } vec_t;

  vec_t vecs[$];

  strobe_byte_receiver #(
    .BUFFER_LEN(BUFFER_LEN), .ADDR_W(ADDR_W), .SYNC_STAGES(SYNC_STAGES),
    .GAP_CYCLES(GAP_CYCLES), .FILTER_CYCLES(FILTER_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_strobe(rx_strobe), .rearm(rearm),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .frame_done(frame_done),
    .overflow(overflow), .gap_timeout(gap_timeout), .byte_count(byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string name, input logic eb, input logic ed, input logic eo,
                           input logic eg, input logic [ADDR_W-1:0] ec);
    cmp({name, ".busy"}, 32'(busy), 32'(eb));
    cmp({name, ".frame_done"}, 32'(frame_done), 32'(ed));
    cmp({name, ".overflow"}, 32'(overflow), 32'(eo));
    cmp({name, ".gap_timeout"}, 32'(gap_timeout), 32'(eg));
    cmp({name, ".byte_count"}, 32'(byte_count), 32'(ec));
  endtask

  task automatic chk_rd(input string name, input logic [ADDR_W-1:0] a, input logic [7:0] e);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    cmp(name, 32'(rd_data), 32'(e));
  endtask

  task automatic send_byte(input logic [7:0] d, input int hold);
    @(negedge clk);
    rx_data   = d;
    rx_strobe = 1'b1;
    repeat (hold) @(negedge clk);
    rx_strobe = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic pulse_rearm();
    @(negedge clk);
    rearm = 1'b1;
    @(negedge clk);
    rearm = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  function automatic void add(input logic [1:0] op, input logic [7:0] d, input logic [ADDR_W-1:0] a,
                              input logic eb, input logic ed, input logic eo, input logic eg,
                              input logic [ADDR_W-1:0] ec, input logic [7:0] er);
    vec_t v;
    v.op = op; v.data = d; v.addr = a;
    v.e_busy = eb; v.e_done = ed; v.e_ovf = eo; v.e_gto = eg;
    v.e_count = ec; v.e_rd = er;
    vecs.push_back(v);
  endfunction

  initial begin
    // Zero-terminated frame, then a re-read of the first byte
    add(OP_STROBE, 8'h48, 4'd0, 1, 0, 0, 0, 4'd1, 8'h48);
    add(OP_STROBE, 8'h69, 4'd1, 1, 0, 0, 0, 4'd2, 8'h69);
    add(OP_STROBE, 8'h00, 4'd2, 0, 1, 0, 0, 4'd3, 8'h00);
    add(OP_READ,   8'h00, 4'd0, 0, 1, 0, 0, 4'd3, 8'h48);
    add(OP_REARM,  8'h00, 4'd9, 0, 0, 0, 0, 4'd0, 8'h00);
    // Full buffer of non-zero bytes closes with overflow; a later strobe is ignored
    for (int i = 1; i <= 7; i++)
      add(OP_STROBE, 8'(i), 4'(i - 1), 1, 0, 0, 0, 4'(i), 8'(i));
    add(OP_STROBE, 8'h08, 4'd7,  0, 1, 1, 0, 4'd8, 8'h08);
    add(OP_STROBE, 8'hFF, 4'd7,  0, 1, 1, 0, 4'd8, 8'h08);
    add(OP_READ,   8'h00, 4'd8,  0, 1, 1, 0, 4'd8, 8'h00);
    add(OP_READ,   8'h00, 4'd15, 0, 1, 1, 0, 4'd8, 8'h00);
    add(OP_REARM,  8'h00, 4'd0,  0, 0, 0, 0, 4'd0, 8'h01);
    // Zero byte landing exactly at the last index: no overflow
    for (int i = 1; i <= 7; i++)
      add(OP_STROBE, 8'(8'h10 + i), 4'(i - 1), 1, 0, 0, 0, 4'(i), 8'(8'h10 + i));
    add(OP_STROBE, 8'h00, 4'd7, 0, 1, 0, 0, 4'd8, 8'h00);

    rst = 1'b0; rx_strobe = 1'b0; rx_data = 8'h00; rearm = 1'b0; rd_addr = '0;
    repeat (3) @(negedge clk);
    chk_state("reset", 0, 0, 0, 0, 4'd0);
    cmp("reset.rd_data", 32'(rd_data), 32'h0);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    foreach (vecs[k]) begin
      case (vecs[k].op)
        OP_STROBE: send_byte(vecs[k].data, 20);
        OP_REARM:  pulse_rearm();
        default:   ;
      endcase
      @(negedge clk);
      rd_addr = vecs[k].addr;
      @(negedge clk);
      chk_state($sformatf("vec%0d", k), vecs[k].e_busy, vecs[k].e_done, vecs[k].e_ovf,
                vecs[k].e_gto, vecs[k].e_count);
      cmp($sformatf("vec%0d.rd_data", k), 32'(rd_data), 32'(vecs[k].e_rd));
    end

    // Read latency: new address shows up only after the next clock edge
    @(negedge clk);
    rd_addr = 4'd6;
    #1 cmp("rd_latency.old", 32'(rd_data), 32'h00);
    @(negedge clk);
    cmp("rd_latency.new", 32'(rd_data), 32'h17);

    // Inter-byte gap closes the frame
    pulse_rearm();
    send_byte(8'h41, 20);
    send_byte(8'h42, 20);
    chk_state("gap.before", 1, 0, 0, 0, 4'd2);
    repeat (40) @(negedge clk);
    chk_state("gap.after", 0, 1, 0, 1, 4'd2);
    chk_rd("gap.rd1", 4'd1, 8'h42);
    pulse_rearm();
    repeat (200) @(negedge clk);
    chk_state("idle_no_timeout", 0, 0, 0, 0, 4'd0);

    // rearm coinciding with the write edge drops the byte
    rd_addr = 4'd0;
    @(negedge clk);
    rx_data = 8'h55; rx_strobe = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    rearm = 1'b1;
    @(negedge clk);
    rearm = 1'b0;
    repeat (17) @(negedge clk);
    rx_strobe = 1'b0;
    repeat (20) @(negedge clk);
    chk_state("rearm_collide", 0, 0, 0, 0, 4'd0);
    cmp("rearm_collide.buf0", 32'(rd_data), 32'h41);

    // Same-edge read and write of buf[0] returns the old byte
    @(negedge clk);
    rx_data = 8'h66; rx_strobe = 1'b1;
    repeat (LAT) @(negedge clk);
    cmp("rw_same.old", 32'(rd_data), 32'h41);
    cmp("rw_same.count", 32'(byte_count), 32'd1);
    @(negedge clk);
    cmp("rw_same.new", 32'(rd_data), 32'h66);
    repeat (15) @(negedge clk);
    rx_strobe = 1'b0;
    repeat (20) @(negedge clk);
    chk_state("after_66", 1, 0, 0, 0, 4'd1);

    // Asynchronous reset mid-frame
    pulse_rearm();
    send_byte(8'h21, 20);
    send_byte(8'h22, 20);
    send_byte(8'h23, 20);
    chk_state("pre_reset", 1, 0, 0, 0, 4'd3);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_state("mid_reset", 0, 0, 0, 0, 4'd0);
    cmp("mid_reset.rd_data", 32'(rd_data), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    send_byte(8'h10, 20);
    send_byte(8'h00, 20);
    chk_state("post_reset", 0, 1, 0, 0, 4'd2);
    chk_rd("post_reset.rd0", 4'd0, 8'h10);
    chk_rd("post_reset.rd2", 4'd2, 8'h23);

`ifdef RX_GLITCH_FILTER_EN
    // Short strobe is rejected, a long one accepted
    pulse_rearm();
    repeat (10) @(negedge clk);
    @(negedge clk);
    rx_data = 8'h99; rx_strobe = 1'b1;
    repeat (2) @(negedge clk);
    rx_strobe = 1'b0;
    repeat (20) @(negedge clk);
    chk_state("glitch.short", 0, 0, 0, 0, 4'd0);
    send_byte(8'h77, 10);
    chk_state("glitch.long", 1, 0, 0, 0, 4'd1);
    chk_rd("glitch.rd0", 4'd0, 8'h77);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
